// File: rtl/padctl_dps_mode_ctrl_if.sv
// Pin bus between the DPS shared-pin sequencer and the pad mux / strap pads.
// The sw_ovr_* pins exist only when PADCTL_DPS_SW_OVERRIDE_EN is defined.
interface padctl_dps_mode_ctrl_if;
  logic       sel_i;
  logic       spi_csb_i;
`ifdef PADCTL_DPS_SW_OVERRIDE_EN
  logic       sw_ovr_en_i;
  logic       sw_ovr_mode_i;
`endif
  logic       jtag_en_o;
  logic       spi_en_o;
  logic       mode_o;
  logic       busy_o;
  logic       drain_timeout_o;
  logic [7:0] switch_cnt_o;

`ifdef PADCTL_DPS_SW_OVERRIDE_EN
  modport master (
    output sel_i, spi_csb_i, sw_ovr_en_i, sw_ovr_mode_i,
    input  jtag_en_o, spi_en_o, mode_o, busy_o, drain_timeout_o, switch_cnt_o
  );
  modport slave (
    input  sel_i, spi_csb_i, sw_ovr_en_i, sw_ovr_mode_i,
    output jtag_en_o, spi_en_o, mode_o, busy_o, drain_timeout_o, switch_cnt_o
  );
`else
  modport master (
    output sel_i, spi_csb_i,
    input  jtag_en_o, spi_en_o, mode_o, busy_o, drain_timeout_o, switch_cnt_o
  );
  modport slave (
    input  sel_i, spi_csb_i,
    output jtag_en_o, spi_en_o, mode_o, busy_o, drain_timeout_o, switch_cnt_o
  );
`endif
endinterface

// File: rtl/padctl_dps_mode_ctrl.sv
// JTAG/SPI ownership sequencer for the DPS0-DPS6 shared pins: debounced strap, SPI drain, dead time.
// Optional software override of the target mode: define PADCTL_DPS_SW_OVERRIDE_EN.
module padctl_dps_mode_ctrl #(
  parameter int unsigned DebounceCycles = 16,
  parameter int unsigned DeadCycles     = 4,
  parameter int unsigned DrainMax       = 32
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  padctl_dps_mode_ctrl_if.slave bus
);

  localparam int unsigned DbW    = $clog2(DebounceCycles);
  localparam int unsigned DeadW  = (DeadCycles > 1) ? $clog2(DeadCycles) : 1;
  localparam int unsigned DrainW = (DrainMax > 1) ? $clog2(DrainMax) : 1;

  localparam logic [DbW-1:0]    DbLast    = DbW'(DebounceCycles - 1);
  localparam logic [DeadW-1:0]  DeadLast  = DeadW'(DeadCycles - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainMax - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_SPI,
    ST_JTAG,
    ST_DRAIN,
    ST_DEAD
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  function automatic logic [DbW-1:0] db_step(input logic [DbW-1:0] v);
    return (v == DbLast) ? v : v + 1'b1;
  endfunction

  logic           sel_p0, sel_s;
  logic           csb_p0, csb_s;
  logic [DbW-1:0] db_cnt, db_cnt_d;
  logic           strap, strap_vld;

  // sel_p0 is the sample about to land in sel_s, so a mismatch means sel_s is changing
  always_comb begin
    if (sel_p0 != sel_s) db_cnt_d = '0;
    else                 db_cnt_d = db_step(db_cnt);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sel_p0    <= 1'b0;
      sel_s     <= 1'b0;
      csb_p0    <= 1'b1;
      csb_s     <= 1'b1;
      db_cnt    <= '0;
      strap     <= 1'b0;
      strap_vld <= 1'b0;
    end else begin
      sel_p0 <= bus.sel_i;
      sel_s  <= sel_p0;
      csb_p0 <= bus.spi_csb_i;
      csb_s  <= csb_p0;
      db_cnt <= db_cnt_d;
      if (db_cnt_d == DbLast) begin
        strap     <= sel_s;
        strap_vld <= 1'b1;
      end
    end
  end

  logic target, init_go;

`ifdef PADCTL_DPS_SW_OVERRIDE_EN
  assign target  = bus.sw_ovr_en_i ? bus.sw_ovr_mode_i : strap;
  assign init_go = strap_vld | bus.sw_ovr_en_i;
`else
  assign target  = strap;
  assign init_go = strap_vld;
`endif

  state_e              state, state_d;
  logic [DeadW-1:0]    dead_cnt, dead_cnt_d;
  logic [DrainW-1:0]   drain_cnt, drain_cnt_d;
  logic                tmo_d;

  always_comb begin
    state_d     = state;
    dead_cnt_d  = dead_cnt;
    drain_cnt_d = drain_cnt;
    tmo_d       = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_go) begin
          state_d    = ST_DEAD;
          dead_cnt_d = '0;
        end
      end
      ST_SPI: begin
        if (target) begin
          if (csb_s) begin
            state_d    = ST_DEAD;
            dead_cnt_d = '0;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      ST_JTAG: begin
        if (!target) begin
          state_d    = ST_DEAD;
          dead_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt + 1'b1;
        if (csb_s || (drain_cnt == DrainLast)) begin
          state_d    = ST_DEAD;
          dead_cnt_d = '0;
          tmo_d      = ~csb_s;
        end
      end
      ST_DEAD: begin
        if (dead_cnt == DeadLast) state_d = target ? ST_JTAG : ST_SPI;
        else                      dead_cnt_d = dead_cnt + 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= ST_INIT;
      dead_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_d;
      dead_cnt  <= dead_cnt_d;
      drain_cnt <= drain_cnt_d;
    end
  end

  logic       jtag_en, spi_en, mode, mode_vld, busy, tmo;
  logic [7:0] switch_cnt;
  logic       enter, new_mode;

  // Modes are only ever entered from DEAD
  assign enter    = (state == ST_DEAD) && (state_d != ST_DEAD);
  assign new_mode = (state_d == ST_JTAG);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      jtag_en    <= 1'b0;
      spi_en     <= 1'b0;
      mode       <= 1'b0;
      mode_vld   <= 1'b0;
      busy       <= 1'b0;
      tmo        <= 1'b0;
      switch_cnt <= 8'd0;
    end else begin
      jtag_en <= (state_d == ST_JTAG);
      spi_en  <= (state_d == ST_SPI);
      busy    <= (state_d == ST_INIT) || (state_d == ST_DRAIN) || (state_d == ST_DEAD);
      tmo     <= tmo_d;
      if (enter) begin
        mode     <= new_mode;
        mode_vld <= 1'b1;
        if (mode_vld && (new_mode != mode)) switch_cnt <= sat_inc8(switch_cnt);
      end
    end
  end

  assign bus.jtag_en_o       = jtag_en;
  assign bus.spi_en_o        = spi_en;
  assign bus.mode_o          = mode;
  assign bus.busy_o          = busy;
  assign bus.drain_timeout_o = tmo;
  assign bus.switch_cnt_o    = switch_cnt;

endmodule

// File: tb/tb_padctl_dps_mode_ctrl.sv
// Scoreboard bench for padctl_dps_mode_ctrl: stimulus queues expected output changes, monitor matches them.
module tb_padctl_dps_mode_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  padctl_dps_mode_ctrl_if bus();

  padctl_dps_mode_ctrl #(
    .DebounceCycles(16),
    .DeadCycles    (4),
    .DrainMax      (32)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic       j;
    logic       s;
    logic       m;
    logic       b;
    logic       t;
    logic [7:0] c;
  } ev_t;

  ev_t exp_q[$];

  function automatic logic [12:0] pack(input ev_t e);
    return {e.j, e.s, e.m, e.b, e.t, e.c};
  endfunction

  task automatic expect_ev(input int c, input logic j, input logic s, input logic m,
                           input logic b, input logic t, input logic [7:0] n);
    ev_t e;
    e.cyc = c; e.j = j; e.s = s; e.m = m; e.b = b; e.t = t; e.c = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every change of the output vector must be the next queued event
  initial begin
    ev_t prev, cur, e;
    prev.cyc = 0; prev.j = 0; prev.s = 0; prev.m = 0; prev.b = 0; prev.t = 0; prev.c = 8'd0;
    forever begin
      @(negedge clk);
      cur.cyc = cyc;
      cur.j = bus.jtag_en_o;
      cur.s = bus.spi_en_o;
      cur.m = bus.mode_o;
      cur.b = bus.busy_o;
      cur.t = bus.drain_timeout_o;
      cur.c = bus.switch_cnt_o;
      checks++;
      if (cur.j === 1'b1 && cur.s === 1'b1) begin
        failures++;
        $display("FAIL exclusive cyc=%0d got jtag_en=1 spi_en=1, required at most one", cyc);
      end
      if (pack(cur) !== pack(prev)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got {j,s,m,b,t,cnt}=%b, required no change",
                   cyc, pack(cur));
        end else begin
          e = exp_q.pop_front();
          if (cur.cyc != e.cyc || pack(cur) !== pack(e)) begin
            failures++;
            $display("FAIL event got cyc=%0d {j,s,m,b,t,cnt}=%b, required cyc=%0d %b",
                     cur.cyc, pack(cur), e.cyc, pack(e));
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    int b, b3, r;
    bus.sel_i     = 1'b1;
    bus.spi_csb_i = 1'b1;
`ifdef PADCTL_DPS_SW_OVERRIDE_EN
    bus.sw_ovr_en_i   = 1'b0;
    bus.sw_ovr_mode_i = 1'b0;
`endif
    rst_n = 1'b0;
    wait_cyc(3);

    // Reset release with strap = JTAG: INIT busy, then JTAG 22 edges later, no count
    r = cyc;
    rst_n = 1'b1;
    expect_ev(r + 1,  0, 0, 0, 1, 0, 8'd0);
    expect_ev(r + 22, 1, 0, 1, 0, 0, 8'd0);
    wait_cyc(30);

    // JTAG -> SPI with no transaction in flight
    b = cyc;
    bus.sel_i = 1'b0;
    expect_ev(b + 18, 0, 0, 1, 1, 0, 8'd1 - 8'd1);
    expect_ev(b + 22, 0, 1, 0, 0, 0, 8'd1);
    wait_cyc(30);

    // 10-cycle strap glitch in SPI: nothing may change
    bus.sel_i = 1'b1;
    wait_cyc(10);
    bus.sel_i = 1'b0;
    wait_cyc(30);

    // SPI -> JTAG with CSB low; CSB released 12 cycles into DRAIN
    bus.spi_csb_i = 1'b0;
    wait_cyc(5);
    b = cyc;
    bus.sel_i = 1'b1;
    expect_ev(b + 18, 0, 0, 0, 1, 0, 8'd1);
    wait_cyc(30);
    b3 = cyc;
    bus.spi_csb_i = 1'b1;
    expect_ev(b3 + 7, 1, 0, 1, 0, 0, 8'd2);
    wait_cyc(20);

    // Back to SPI, then a switch with CSB stuck low: forced drain after 32 cycles
    b = cyc;
    bus.sel_i = 1'b0;
    expect_ev(b + 18, 0, 0, 1, 1, 0, 8'd2);
    expect_ev(b + 22, 0, 1, 0, 0, 0, 8'd3);
    wait_cyc(30);
    bus.spi_csb_i = 1'b0;
    wait_cyc(5);
    b = cyc;
    bus.sel_i = 1'b1;
    expect_ev(b + 18, 0, 0, 0, 1, 0, 8'd3);
    expect_ev(b + 50, 0, 0, 0, 1, 1, 8'd3);
    expect_ev(b + 51, 0, 0, 0, 1, 0, 8'd3);
    expect_ev(b + 54, 1, 0, 1, 0, 0, 8'd4);
    wait_cyc(60);
    bus.spi_csb_i = 1'b1;
    wait_cyc(5);

    // Strap reverses while draining: SPI re-entered, count unchanged
    b = cyc;
    bus.sel_i = 1'b0;
    expect_ev(b + 18, 0, 0, 1, 1, 0, 8'd4);
    expect_ev(b + 22, 0, 1, 0, 0, 0, 8'd5);
    wait_cyc(30);
    bus.spi_csb_i = 1'b0;
    wait_cyc(5);
    b = cyc;
    bus.sel_i = 1'b1;
    expect_ev(b + 18, 0, 0, 0, 1, 0, 8'd5);
    wait_cyc(20);
    bus.sel_i = 1'b0;
    wait_cyc(20);
    b3 = cyc;
    bus.spi_csb_i = 1'b1;
    expect_ev(b3 + 7, 0, 1, 0, 0, 0, 8'd5);
    wait_cyc(20);

    // Reset asserted during DEAD: everything clears on that edge, then restarts
    b = cyc;
    bus.sel_i = 1'b1;
    expect_ev(b + 18, 0, 0, 0, 1, 0, 8'd5);
    wait_cyc(19);
    rst_n = 1'b0;
    expect_ev(b + 20, 0, 0, 0, 0, 0, 8'd0);
    wait_cyc(3);
    r = cyc;
    rst_n = 1'b1;
    expect_ev(r + 1,  0, 0, 0, 1, 0, 8'd0);
    expect_ev(r + 22, 1, 0, 1, 0, 0, 8'd0);
    wait_cyc(30);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got %0d outstanding, required 0 (next due cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
